ascon_serdes: RTL and testbench

Parametrised serial front-end for the Ascon AEAD core: deserialises key, nonce, associated data, payload and (for decryption) the expected tag over W-bit lanes with a valid/ready handshake. It launches one AsconCore operation, then serialises ciphertext/plaintext and tag back out MSB-first under output backpressure. AsconCore is instantiated alongside, not inside; this block drives its parallel buses. It supersedes the fixed 1-bit, free-running-counter input wrapper.

---
 rtl/ascon_serdes.sv | 224 ++++++++++++++++++++++
 tb/tb_ascon_serdes.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_serdes.sv
// ascon_serdes: W-bit serial front-end for a parallel AsconCore.
// Loads key/nonce/AD/payload (and the expected tag when enabled) MSB-first,
// launches one core operation, then unloads result and tag MSB-first.
// Optional feature macro: ASCON_TAG_CHECK_EN. When it is defined, an expected
// tag is loaded and a decrypt whose tag does not match releases zeros
// instead of the payload.
module ascon_serdes #(
  parameter int K = 128,
  parameter int L = 32,
  parameter int Y = 32,
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] keyxSI,
  input  logic [W-1:0] noncexSI,
  input  logic [W-1:0] associated_dataxSI,
  input  logic [W-1:0] input_dataxSI,
  input  logic [W-1:0] tagxSI,
  input  logic         in_validxSI,
  output logic         in_readyxSO,
  input  logic         ascon_startxSI,
  input  logic         decrypt,
  output logic [W-1:0] output_dataxSO,
  output logic [W-1:0] tagxSO,
  output logic         out_validxSO,
  input  logic         out_readyxSI,
  output logic         auth_failxSO,
  output logic         ascon_readyxSO,
  output logic [K-1:0] core_key,
  output logic [127:0] core_nonce,
  output logic [L-1:0] core_ad,
  output logic [Y-1:0] core_data,
  output logic         core_startxSO,
  output logic         core_decryptxSO,
  input  logic [Y-1:0] core_outxSI,
  input  logic [127:0] core_tagxSI,
  input  logic         core_donexSI
);

  localparam int NT = 128;

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int NL = imax(imax(K, NT), imax(L, Y)) / W;
  localparam int NU = imax(Y, NT) / W;
  localparam int CW = $clog2(imax(NL, NU) + 1);

  localparam logic [CW-1:0] C_KB      = CW'(K / W);
  localparam logic [CW-1:0] C_NB      = CW'(NT / W);
  localparam logic [CW-1:0] C_LB      = CW'(L / W);
  localparam logic [CW-1:0] C_YB      = CW'(Y / W);
  localparam logic [CW-1:0] C_NL_LAST = CW'(NL - 1);
  localparam logic [CW-1:0] C_NU_LAST = CW'(NU - 1);

  // Lane width must tile every field exactly.
  if ((W < 1) || ((K % W) != 0) || ((NT % W) != 0) || ((L % W) != 0) || ((Y % W) != 0)) begin : g_bad_lane_width
    $error("ascon_serdes: W must divide K, 128, L and Y");
  end

  typedef enum logic [1:0] {S_LOAD = 2'd0, S_ARMED = 2'd1, S_RUN = 2'd2, S_UNLOAD = 2'd3} state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_in_ready;
  logic            r_out_valid;
  logic [CW-1:0]   r_bcnt;
  logic [K-1:0]    r_key;
  logic [NT-1:0]   r_nonce;
  logic [L-1:0]    r_ad;
  logic [Y-1:0]    r_data;
  logic [Y-1:0]    r_out;
  logic [NT-1:0]   r_tago;
  logic            r_core_start;
  logic            r_core_decrypt;
  logic            w_in_fire;
  logic            w_out_fire;
  logic            w_load_last;
  logic            w_unload_last;

`ifdef ASCON_TAG_CHECK_EN
  logic [NT-1:0]   r_tag_exp;
  logic            r_auth_fail;
  assign auth_failxSO = r_auth_fail;
`else
  logic            w_unused_tag_lane;
  assign w_unused_tag_lane = ^tagxSI;
  assign auth_failxSO      = 1'b0;
`endif

  // Handshakes only count while the matching ready/valid register is up,
  // which keeps the bus quiet for the first cycle after reset release.
  assign w_in_fire     = in_validxSI & r_in_ready;
  assign w_out_fire    = out_readyxSI & r_out_valid;
  assign w_load_last   = w_in_fire & (r_bcnt == C_NL_LAST);
  assign w_unload_last = w_out_fire & (r_bcnt == C_NU_LAST);

  assign in_readyxSO     = r_in_ready;
  assign out_validxSO    = r_out_valid;
  assign core_key        = r_key;
  assign core_nonce      = r_nonce;
  assign core_ad         = r_ad;
  assign core_data       = r_data;
  assign core_startxSO   = r_core_start;
  assign core_decryptxSO = r_core_decrypt;

  // State register plus the registered ready/valid decoded from next state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_LOAD;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_LOAD);
      r_out_valid <= (w_next == S_UNLOAD);
    end
  end

  // Next-state decode; launch and done are only honoured in their own state
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_LOAD:   w_next = w_load_last    ? S_ARMED  : S_LOAD;
      S_ARMED:  w_next = ascon_startxSI ? S_RUN    : S_ARMED;
      S_RUN:    w_next = core_donexSI   ? S_UNLOAD : S_RUN;
      S_UNLOAD: w_next = w_unload_last  ? S_LOAD   : S_UNLOAD;
      default:  w_next = S_LOAD;
    endcase
  end

  // Output lanes present the top W bits while unloading; ready pulses on the final accepted beat
  always_comb begin
    output_dataxSO = {W{1'b0}};
    tagxSO         = {W{1'b0}};
    ascon_readyxSO = 1'b0;
    case (r_state)
      S_UNLOAD: begin
        output_dataxSO = r_out[Y-1 -: W];
        tagxSO         = r_tago[NT-1 -: W];
        ascon_readyxSO = w_unload_last;
      end
      default: begin
        output_dataxSO = {W{1'b0}};
        tagxSO         = {W{1'b0}};
        ascon_readyxSO = 1'b0;
      end
    endcase
  end

  // Field shift registers, beat counter and core launch/result capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bcnt         <= {CW{1'b0}};
      r_key          <= {K{1'b0}};
      r_nonce        <= {NT{1'b0}};
      r_ad           <= {L{1'b0}};
      r_data         <= {Y{1'b0}};
      r_out          <= {Y{1'b0}};
      r_tago         <= {NT{1'b0}};
      r_core_start   <= 1'b0;
      r_core_decrypt <= 1'b0;
`ifdef ASCON_TAG_CHECK_EN
      r_tag_exp      <= {NT{1'b0}};
      r_auth_fail    <= 1'b0;
`endif
    end else begin
      r_core_start <= 1'b0;
      case (r_state)
        S_LOAD: begin
          if (w_in_fire) begin
            r_bcnt <= w_load_last ? {CW{1'b0}} : (r_bcnt + CW'(1));
            // Each field stops shifting once it has its full length; later lanes are dropped.
            if (r_bcnt < C_KB) r_key   <= K'({r_key, keyxSI});
            if (r_bcnt < C_NB) r_nonce <= NT'({r_nonce, noncexSI});
            if (r_bcnt < C_LB) r_ad    <= L'({r_ad, associated_dataxSI});
            if (r_bcnt < C_YB) r_data  <= Y'({r_data, input_dataxSI});
`ifdef ASCON_TAG_CHECK_EN
            if (r_bcnt < C_NB) r_tag_exp <= NT'({r_tag_exp, tagxSI});
`endif
          end
        end
        S_ARMED: begin
          if (ascon_startxSI) begin
            r_core_start   <= 1'b1;
            r_core_decrypt <= decrypt;
`ifdef ASCON_TAG_CHECK_EN
            r_auth_fail    <= 1'b0;
`endif
          end
        end
        S_RUN: begin
          if (core_donexSI) begin
            r_tago <= core_tagxSI;
`ifdef ASCON_TAG_CHECK_EN
            // A failed decrypt withholds the plaintext by capturing zeros.
            if (r_core_decrypt && (core_tagxSI != r_tag_exp)) begin
              r_auth_fail <= 1'b1;
              r_out       <= {Y{1'b0}};
            end else begin
              r_auth_fail <= 1'b0;
              r_out       <= core_outxSI;
            end
`else
            r_out <= core_outxSI;
`endif
          end
        end
        S_UNLOAD: begin
          if (w_out_fire) begin
            // Zeros shift in, so an exhausted field naturally drives 0.
            r_out  <= r_out << W;
            r_tago <= r_tago << W;
            r_bcnt <= w_unload_last ? {CW{1'b0}} : (r_bcnt + CW'(1));
          end
        end
        default: r_bcnt <= {CW{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_ascon_serdes.sv
// Bench for ascon_serdes: one W=1 instance (basic 128-beat flow) and one
// W=8 instance (stalls, backpressure, tag check, resets, stray done).
module tb_ascon_serdes;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct packed { logic [7:0] d; logic [7:0] t; } beat_t;
  beat_t q[$];

`ifdef ASCON_TAG_CHECK_EN
  localparam bit TC = 1'b1;
`else
  localparam bit TC = 1'b0;
`endif

  localparam logic [127:0] KEY1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] NON1 = 128'hf0e1d2c3b4a5968778695a4b3c2d1e0f;
  localparam logic [127:0] TAGX = 128'h0123456789abcdef0123456789abcdef;

  // ---------------- W = 8 instance ----------------
  logic [7:0]   a_key, a_nonce, a_ad, a_din, a_tag, a_dout, a_tout;
  logic         a_in_valid, a_in_ready, a_start, a_dec, a_out_valid, a_out_ready, a_auth, a_rdy;
  logic [127:0] a_ckey, a_cnonce, a_ctag;
  logic [31:0]  a_cad, a_cdata, a_cout;
  logic         a_cstart, a_cdec, a_cdone;

  ascon_serdes #(.K(128), .L(32), .Y(32), .W(8)) u_dut8 (
    .clk(clk), .rst(rst),
    .keyxSI(a_key), .noncexSI(a_nonce), .associated_dataxSI(a_ad), .input_dataxSI(a_din), .tagxSI(a_tag),
    .in_validxSI(a_in_valid), .in_readyxSO(a_in_ready), .ascon_startxSI(a_start), .decrypt(a_dec),
    .output_dataxSO(a_dout), .tagxSO(a_tout), .out_validxSO(a_out_valid), .out_readyxSI(a_out_ready),
    .auth_failxSO(a_auth), .ascon_readyxSO(a_rdy),
    .core_key(a_ckey), .core_nonce(a_cnonce), .core_ad(a_cad), .core_data(a_cdata),
    .core_startxSO(a_cstart), .core_decryptxSO(a_cdec),
    .core_outxSI(a_cout), .core_tagxSI(a_ctag), .core_donexSI(a_cdone)
  );

  // ---------------- W = 1 instance ----------------
  logic         b_key, b_nonce, b_ad, b_din, b_tag, b_dout, b_tout;
  logic         b_in_valid, b_in_ready, b_start, b_dec, b_out_valid, b_out_ready, b_auth, b_rdy;
  logic [127:0] b_ckey, b_cnonce, b_ctag;
  logic [31:0]  b_cad, b_cdata, b_cout;
  logic         b_cstart, b_cdec, b_cdone;

  ascon_serdes #(.K(128), .L(32), .Y(32), .W(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .keyxSI(b_key), .noncexSI(b_nonce), .associated_dataxSI(b_ad), .input_dataxSI(b_din), .tagxSI(b_tag),
    .in_validxSI(b_in_valid), .in_readyxSO(b_in_ready), .ascon_startxSI(b_start), .decrypt(b_dec),
    .output_dataxSO(b_dout), .tagxSO(b_tout), .out_validxSO(b_out_valid), .out_readyxSI(b_out_ready),
    .auth_failxSO(b_auth), .ascon_readyxSO(b_rdy),
    .core_key(b_ckey), .core_nonce(b_cnonce), .core_ad(b_cad), .core_data(b_cdata),
    .core_startxSO(b_cstart), .core_decryptxSO(b_cdec),
    .core_outxSI(b_cout), .core_tagxSI(b_ctag), .core_donexSI(b_cdone)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reset asserted between clock edges; outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    a_out_ready = 1'b0;
    #1;
    chk("rst_in_ready", 128'(a_in_ready), 128'(1'b0));
    chk("rst_out_valid", 128'(a_out_valid), 128'(1'b0));
    chk("rst_lanes", 128'({a_dout, a_tout}), 128'(16'h0000));
    chk("rst_flags", 128'({a_auth, a_rdy, a_cstart, a_cdec}), 128'(4'h0));
    chk("rst_core_key", a_ckey, 128'h0);
    chk("rst_core_misc", {a_cnonce[63:0], a_cad, a_cdata}, 128'h0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 128'(a_in_ready), 128'(1'b1));
  endtask

  task automatic a_load(input logic [127:0] key, input logic [127:0] non, input logic [127:0] tg,
                        input logic [31:0] ad, input logic [31:0] dat, input bit gappy, input bit poke_start);
    int i;
    int cyc;
    bit ph;
    i = 0; cyc = 0; ph = 1'b0;
    while (i < 16 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (poke_start) begin
        chk("start_in_load", 128'(a_cstart), 128'(1'b0));
        a_start = 1'b1;
      end
      if (gappy && ph) begin
        a_in_valid = 1'b0;
      end else begin
        a_in_valid = 1'b1;
        a_key   = key[127-8*i -: 8];
        a_nonce = non[127-8*i -: 8];
        a_tag   = tg[127-8*i -: 8];
        a_ad    = (i < 4) ? ad[31-8*i -: 8]  : 8'($urandom);
        a_din   = (i < 4) ? dat[31-8*i -: 8] : 8'($urandom);
        if (a_in_ready) i++;
      end
      ph = ~ph;
    end
    if (i < 16) chk("load_timeout", 128'(i), 128'(16));
    @(negedge clk);
    a_in_valid = 1'b0;
    a_start    = 1'b0;
    chk("armed_in_ready", 128'(a_in_ready), 128'(1'b0));
    chk("armed_core_start", 128'(a_cstart), 128'(1'b0));
    chk("core_key", a_ckey, key);
    chk("core_nonce", a_cnonce, non);
    chk("core_ad_data", 128'({a_cad, a_cdata}), 128'({ad, dat}));
  endtask

  task automatic a_launch(input bit dec);
    @(negedge clk);
    a_start = 1'b1;
    a_dec   = dec;
    @(negedge clk);
    a_start = 1'b0;
    a_dec   = 1'b0;
    chk("core_start_high", 128'(a_cstart), 128'(1'b1));
    chk("core_decrypt", 128'(a_cdec), 128'(dec));
    chk("auth_cleared", 128'(a_auth), 128'(1'b0));
    @(negedge clk);
    chk("core_start_pulse", 128'(a_cstart), 128'(1'b0));
  endtask

  task automatic a_done(input logic [31:0] res, input logic [127:0] ctag, input bit exp_fail);
    @(negedge clk);
    a_cdone = 1'b1;
    a_cout  = res;
    a_ctag  = ctag;
    for (int j = 0; j < 16; j++)
      q.push_back(beat_t'{d: ((j < 4) && !exp_fail) ? res[31-8*j -: 8] : 8'h00, t: ctag[127-8*j -: 8]});
    @(negedge clk);
    a_cdone = 1'b0;
    chk("first_out_valid", 128'(a_out_valid), 128'(1'b1));
    chk("auth_fail", 128'(a_auth), 128'(exp_fail));
  endtask

  // Unload against the scoreboard; lanes are compared every cycle, so a stall also checks they hold.
  task automatic a_unload(input int stall_at, input int stall_len, input int stop_after);
    int acc;
    int cyc;
    int st;
    acc = 0; cyc = 0; st = 0;
    while (q.size() > 0 && acc < stop_after && cyc < 200) begin
      chk("out_valid_held", 128'(a_out_valid), 128'(1'b1));
      chk("out_lanes", 128'({a_dout, a_tout}), 128'({q[0].d, q[0].t}));
      if (acc == stall_at && st < stall_len) begin
        a_out_ready = 1'b0;
        st++;
      end else begin
        a_out_ready = 1'b1;
      end
      #1;
      chk("ascon_ready", 128'(a_rdy), 128'(a_out_ready && (q.size() == 1)));
      if (a_out_ready) begin
        void'(q.pop_front());
        acc++;
      end
      @(negedge clk);
      cyc++;
    end
    a_out_ready = 1'b0;
    if (cyc >= 200) begin
      chk("unload_timeout", 128'(q.size()), 128'(0));
      q.delete();
    end
    if (acc == 16) begin
      chk("back_to_load", 128'({a_in_ready, a_out_valid}), 128'(2'b10));
    end
  endtask

  task automatic b_unload();
    int cyc;
    cyc = 0;
    b_out_ready = 1'b1;
    while (q.size() > 0 && cyc < 400) begin
      chk("b_out_valid", 128'(b_out_valid), 128'(1'b1));
      chk("b_out_lanes", 128'({b_dout, b_tout}), 128'({q[0].d[0], q[0].t[0]}));
      chk("b_ascon_ready", 128'(b_rdy), 128'(q.size() == 1));
      void'(q.pop_front());
      @(negedge clk);
      cyc++;
    end
    b_out_ready = 1'b0;
    if (q.size() > 0) begin
      chk("b_unload_timeout", 128'(q.size()), 128'(0));
      q.delete();
    end
    chk("b_back_to_load", 128'({b_in_ready, b_out_valid, b_rdy}), 128'(3'b100));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    {a_key, a_nonce, a_ad, a_din, a_tag} = '0;
    {a_in_valid, a_start, a_dec, a_out_ready, a_cdone} = '0;
    a_cout = '0; a_ctag = '0;
    {b_key, b_nonce, b_ad, b_din, b_tag} = '0;
    {b_in_valid, b_start, b_dec, b_out_ready, b_cdone} = '0;
    b_cout = '0; b_ctag = '0;

    // Power-on reset state of both instances.
    do_reset();
    chk("b_rst_release_ready", 128'(b_in_ready), 128'(1'b1));

    // W=1: 128 continuous beats, encrypt, 128 output beats.
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      chk("b_in_ready_load", 128'(b_in_ready), 128'(1'b1));
      b_in_valid = 1'b1;
      b_key   = KEY1[127-i];
      b_nonce = NON1[127-i];
      b_ad    = (i < 32) ? 1'(32'hcafef00d >> (31 - i)) : 1'($urandom);
      b_din   = (i < 32) ? 1'(32'h12345678 >> (31 - i)) : 1'($urandom);
    end
    @(negedge clk);
    b_in_valid = 1'b0;
    chk("b_armed", 128'(b_in_ready), 128'(1'b0));
    chk("b_core_key", b_ckey, KEY1);
    chk("b_core_nonce", b_cnonce, NON1);
    chk("b_core_ad_data", 128'({b_cad, b_cdata}), 128'({32'hcafef00d, 32'h12345678}));
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    chk("b_core_start", 128'(b_cstart), 128'(1'b1));
    @(negedge clk);
    b_cdone = 1'b1;
    b_cout  = 32'hdeadbeef;
    b_ctag  = TAGX;
    for (int j = 0; j < 128; j++)
      q.push_back(beat_t'{d: (j < 32) ? 8'(b_cout[31-j]) : 8'h00, t: 8'(TAGX[127-j])});
    @(negedge clk);
    b_cdone = 1'b0;
    chk("b_first_bit", 128'(b_dout), 128'(1'b1));
    b_unload();

    // W=8: in_valid every other cycle with a launch request held during LOAD; output stall of 5 cycles.
    a_load(KEY1, NON1, ~TAGX, 32'ha1b2c3d4, 32'h55aa33cc, 1'b1, 1'b1);
    a_launch(1'b0);
    a_done(32'h89abcdef, TAGX, 1'b0);
    a_unload(6, 5, 16);

    // Stray done in ARMED is ignored; decrypt with expected tag off by bit 0.
    a_load(~KEY1, ~NON1, TAGX ^ 128'h1, 32'h0badf00d, 32'hfeedface, 1'b0, 1'b0);
    @(negedge clk);
    a_cdone = 1'b1;
    a_cout  = 32'h11111111;
    @(negedge clk);
    a_cdone = 1'b0;
    chk("armed_done_ignored", 128'({a_in_ready, a_out_valid, a_cstart}), 128'(3'b000));
    @(negedge clk);
    chk("armed_still", 128'({a_in_ready, a_out_valid}), 128'(2'b00));
    a_launch(1'b1);
    a_done(32'hfeedface, TAGX, TC);
    a_unload(0, 0, 16);
    chk("auth_fail_held", 128'(a_auth), 128'(TC));

    // Decrypt with matching expected tag: plaintext released.
    a_load(KEY1, NON1, TAGX, 32'h01020304, 32'hc0ffee00, 1'b0, 1'b0);
    a_launch(1'b1);
    a_done(32'h600dcafe, TAGX, 1'b0);
    a_unload(2, 1, 16);

    // Reset during RUN, then a done pulse after release must not start an unload.
    a_load(NON1, KEY1, TAGX, 32'h13579bdf, 32'h2468ace0, 1'b0, 1'b0);
    a_launch(1'b0);
    do_reset();
    a_cdone = 1'b1;
    @(negedge clk);
    a_cdone = 1'b0;
    chk("done_in_load_ignored", 128'({a_in_ready, a_out_valid}), 128'(2'b10));

    // Reset during unload after 3 beats.
    a_load(KEY1, ~NON1, TAGX, 32'h76543210, 32'habcdef01, 1'b0, 1'b0);
    a_launch(1'b0);
    a_done(32'habcdef01, ~TAGX, 1'b0);
    a_unload(99, 0, 3);
    do_reset();
    q.delete();

    // Fresh full transaction after the mid-unload reset.
    a_load(~KEY1, NON1, TAGX, 32'h9e3779b9, 32'h7f4a7c15, 1'b0, 1'b0);
    a_launch(1'b0);
    a_done(32'h31415926, TAGX ^ 128'hff, 1'b0);
    a_unload(15, 3, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
